// File: rtl/dram_sched_pkg.sv
// Shared types for the DRAM command scheduler: FSM states, command encoding,
// default timing values and the column-command selector.
package dram_sched_pkg;

    localparam int DEF_BGWIDTH  = 2;
    localparam int DEF_BAWIDTH  = 2;
    localparam int DEF_ROWWIDTH = 16;
    localparam int DEF_BL       = 8;
    localparam int DEF_TRCD     = 15;
    localparam int DEF_TRP      = 16;
    localparam int DEF_TRFC     = 34;
    localparam int DEF_TREFI    = 10400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REF_PRE,
        ST_WAIT_RP,
        ST_WAIT_RPA,
        ST_WAIT_RCD,
        ST_BURST,
        ST_WAIT_APRE,
        ST_WAIT_RFC
    } sched_state_t;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PR,
        CMD_PRA,
        CMD_RD,
        CMD_WR,
        CMD_RDA,
        CMD_WRA,
        CMD_REF
    } dram_cmd_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic dram_cmd_t col_cmd(input logic wr, input logic autopre);
        if (autopre) return wr ? CMD_WRA : CMD_RDA;
        return wr ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/dram_cmd_scheduler_if.sv
// Host request port and DRAM command strobes of the scheduler.
// slave = scheduler side, master = host / bank-array side.
interface dram_cmd_scheduler_if #(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int ROWWIDTH = 16
);
    // A zero-width bank group (DDR3) is carried as one bit that the host ties to 0.
    localparam int BGW = (BGWIDTH > 0) ? BGWIDTH : 1;

    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [BGW-1:0]      req_bg;
    logic [BAWIDTH-1:0]  req_ba;
    logic [ROWWIDTH-1:0] req_row;

    logic [BGW-1:0]      bg;
    logic [BAWIDTH-1:0]  ba;
    logic                ACT;
    logic                PR;
    logic                PRA;
    logic                RD;
    logic                WR;
    logic                RDA;
    logic                WRA;
    logic                REF;
    logic                done;
    logic                busy;

    modport master (
        output req_valid, req_wr, req_bg, req_ba, req_row,
        input  req_ready, bg, ba, ACT, PR, PRA, RD, WR, RDA, WRA, REF, done, busy
    );

    modport slave (
        input  req_valid, req_wr, req_bg, req_ba, req_row,
        output req_ready, bg, ba, ACT, PR, PRA, RD, WR, RDA, WRA, REF, done, busy
    );

endinterface

// File: rtl/dram_cmd_scheduler_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
// A second expiry while pending simply keeps the single flag set.
module refresh_timer #(
    parameter int TREFI = 10400
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic pending
);
    localparam int CW = (TREFI > 2) ? $clog2(TREFI) : 1;

    logic [CW-1:0] cnt_reg;
    logic          pending_reg;
    logic          expire;

    assign expire = (cnt_reg == CW'(TREFI - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            cnt_reg     <= expire ? '0 : cnt_reg + CW'(1);
            pending_reg <= expire | (pending_reg & ~clr);
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/dram_cmd_scheduler.sv
// DRAM command scheduler: one request at a time, open-row tracking, PR/ACT
// insertion, tRP/tRCD/tRFC/burst spacing and periodic all-bank refresh.
// Define AUTOPRE_EN for the closed-page policy (RDA/WRA plus a tRP tail).
module dram_cmd_scheduler
    import dram_sched_pkg::*;
#(
    parameter int BGWIDTH  = DEF_BGWIDTH,
    parameter int BAWIDTH  = DEF_BAWIDTH,
    parameter int ROWWIDTH = DEF_ROWWIDTH,
    parameter int BL       = DEF_BL,
    parameter int TRCD     = DEF_TRCD,
    parameter int TRP      = DEF_TRP,
    parameter int TRFC     = DEF_TRFC,
    parameter int TREFI    = DEF_TREFI
) (
    input logic                 clk,
    input logic                 reset,
    dram_cmd_scheduler_if.slave sif
);
    localparam int BGW    = (BGWIDTH > 0) ? BGWIDTH : 1;
    localparam int IDXW   = BGW + BAWIDTH;
    localparam int NBANKS = 1 << IDXW;
    localparam int CNTW   = $clog2(max4(TRFC, TRP, TRCD, BL) + 1);

`ifdef AUTOPRE_EN
    localparam bit CLOSED_PAGE = 1'b1;
`else
    localparam bit CLOSED_PAGE = 1'b0;
`endif

    sched_state_t        state_reg;
    dram_cmd_t           cmd_reg;
    logic [CNTW-1:0]     cnt_reg;
    logic                wr_reg;
    logic [IDXW-1:0]     idx_reg;
    logic [ROWWIDTH-1:0] row_reg;
    logic [BGW-1:0]      bg_reg;
    logic [BAWIDTH-1:0]  ba_reg;
    logic                done_reg;
    logic                ready_en_reg;

    logic [NBANKS-1:0]   open_vld_reg;
    logic [NBANKS-1:0]   open_vld_next;
    logic [ROWWIDTH-1:0] open_row [NBANKS];

    logic                ref_pending;
    logic                ref_clr;
    logic [IDXW-1:0]     acc_idx;
    logic                req_ready_int;
    logic                accept;
    logic                acc_open;
    logic                acc_hit;
    logic                cnt_last;
    logic                pr_issue;
    logic                col_issue;
    logic                tbl_set;
    logic                tbl_clr;
    logic                tbl_clr_all;
    logic [IDXW-1:0]     tbl_idx;
    logic [ROWWIDTH-1:0] tbl_row;

    refresh_timer #(.TREFI(TREFI)) u_refresh_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (ref_clr),
        .pending (ref_pending)
    );

    // ready_en keeps req_ready low while reset is held.
    assign req_ready_int = (state_reg == ST_IDLE) & ~ref_pending & ready_en_reg;
    assign accept        = req_ready_int & sif.req_valid;
    assign acc_idx       = {sif.req_bg, sif.req_ba};
    assign acc_open      = open_vld_reg[acc_idx];
    assign acc_hit       = acc_open && (open_row[acc_idx] == sif.req_row);
    assign cnt_last      = (cnt_reg == CNTW'(1));
    assign ref_clr       = (state_reg == ST_WAIT_RFC) & cnt_last;

    assign pr_issue    = accept & acc_open & ~acc_hit;
    assign col_issue   = (accept & acc_hit) | ((state_reg == ST_WAIT_RCD) & cnt_last);
    assign tbl_set     = (accept & ~acc_open) | ((state_reg == ST_WAIT_RP) & cnt_last);
    assign tbl_clr     = pr_issue | (CLOSED_PAGE & col_issue);
    assign tbl_clr_all = (state_reg == ST_REF_PRE) & (|open_vld_reg);
    assign tbl_idx     = accept ? acc_idx : idx_reg;
    assign tbl_row     = accept ? sif.req_row : row_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NBANKS; gi++) begin : g_bank
            assign open_vld_next[gi] =
                tbl_clr_all                              ? 1'b0 :
                (tbl_set && (tbl_idx == IDXW'(gi)))      ? 1'b1 :
                (tbl_clr && (tbl_idx == IDXW'(gi)))      ? 1'b0 :
                                                           open_vld_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) open_vld_reg <= '0;
        else       open_vld_reg <= open_vld_next;
    end

    // Row store needs no reset: a row is only read when its valid bit is set.
    always_ff @(posedge clk) begin
        if (tbl_set) open_row[tbl_idx] <= tbl_row;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= CMD_NOP;
            cnt_reg      <= '0;
            wr_reg       <= 1'b0;
            idx_reg      <= '0;
            row_reg      <= '0;
            bg_reg       <= '0;
            ba_reg       <= '0;
            done_reg     <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            cmd_reg      <= CMD_NOP;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ref_pending) begin
                        state_reg <= ST_REF_PRE;
                    end else if (accept) begin
                        wr_reg  <= sif.req_wr;
                        idx_reg <= acc_idx;
                        row_reg <= sif.req_row;
                        bg_reg  <= sif.req_bg;
                        ba_reg  <= sif.req_ba;
                        if (acc_hit) begin
                            cmd_reg   <= col_cmd(sif.req_wr, CLOSED_PAGE);
                            cnt_reg   <= CNTW'(BL);
                            state_reg <= ST_BURST;
                        end else if (acc_open) begin
                            cmd_reg   <= CMD_PR;
                            cnt_reg   <= CNTW'(TRP);
                            state_reg <= ST_WAIT_RP;
                        end else begin
                            cmd_reg   <= CMD_ACT;
                            cnt_reg   <= CNTW'(TRCD);
                            state_reg <= ST_WAIT_RCD;
                        end
                    end
                end
                ST_WAIT_RP: begin
                    if (cnt_last) begin
                        cmd_reg   <= CMD_ACT;
                        cnt_reg   <= CNTW'(TRCD);
                        state_reg <= ST_WAIT_RCD;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                ST_WAIT_RCD: begin
                    if (cnt_last) begin
                        cmd_reg   <= col_cmd(wr_reg, CLOSED_PAGE);
                        cnt_reg   <= CNTW'(BL);
                        state_reg <= ST_BURST;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                ST_BURST: begin
                    if (cnt_last) begin
`ifdef AUTOPRE_EN
                        cnt_reg   <= CNTW'(TRP);
                        state_reg <= ST_WAIT_APRE;
`else
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                ST_WAIT_APRE: begin
                    if (cnt_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                ST_REF_PRE: begin
                    bg_reg <= '0;
                    ba_reg <= '0;
                    if (|open_vld_reg) begin
                        cmd_reg   <= CMD_PRA;
                        cnt_reg   <= CNTW'(TRP);
                        state_reg <= ST_WAIT_RPA;
                    end else begin
                        cmd_reg   <= CMD_REF;
                        cnt_reg   <= CNTW'(TRFC);
                        state_reg <= ST_WAIT_RFC;
                    end
                end
                ST_WAIT_RPA: begin
                    if (cnt_last) begin
                        cmd_reg   <= CMD_REF;
                        cnt_reg   <= CNTW'(TRFC);
                        state_reg <= ST_WAIT_RFC;
                    end else begin
                        cnt_reg <= cnt_reg - CNTW'(1);
                    end
                end
                ST_WAIT_RFC: begin
                    if (cnt_last) state_reg <= ST_IDLE;
                    else          cnt_reg   <= cnt_reg - CNTW'(1);
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sif.req_ready = req_ready_int;
    assign sif.bg        = bg_reg;
    assign sif.ba        = ba_reg;
    assign sif.ACT       = (cmd_reg == CMD_ACT);
    assign sif.PR        = (cmd_reg == CMD_PR);
    assign sif.PRA       = (cmd_reg == CMD_PRA);
    assign sif.RD        = (cmd_reg == CMD_RD);
    assign sif.WR        = (cmd_reg == CMD_WR);
    assign sif.REF       = (cmd_reg == CMD_REF);
`ifdef AUTOPRE_EN
    assign sif.RDA       = (cmd_reg == CMD_RDA);
    assign sif.WRA       = (cmd_reg == CMD_WRA);
`else
    assign sif.RDA       = 1'b0;
    assign sif.WRA       = 1'b0;
`endif
    assign sif.done      = done_reg;
    assign sif.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench for dram_cmd_scheduler: directed latency/refresh scenarios
// plus randomized back-to-back traffic against a latency-table reference model.
`timescale 1ns/1ps
module tb_dram_cmd_scheduler;
    localparam int BGWIDTH  = 2;
    localparam int BAWIDTH  = 2;
    localparam int ROWWIDTH = 16;
    localparam int BL       = 8;
    localparam int TRCD     = 15;
    localparam int TRP      = 16;
    localparam int TRFC     = 34;
    localparam int TREFI    = 10400;
    localparam int NB       = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dram_cmd_scheduler_if #(.BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ROWWIDTH(ROWWIDTH)) sif ();

    dram_cmd_scheduler #(
        .BGWIDTH(BGWIDTH), .BAWIDTH(BAWIDTH), .ROWWIDTH(ROWWIDTH), .BL(BL),
        .TRCD(TRCD), .TRP(TRP), .TRFC(TRFC), .TREFI(TREFI)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    int errors = 0;
    int checks = 0;
    int n_req  = 0;
    int edges_since_rst;

    // Reference model: which banks are open on which row, and the last commanded bank.
    bit m_open [NB];
    int m_row  [NB];
    int m_last_bank;
    int cur_bg, cur_ba, cur_row;
    bit cur_wr;

    always @(posedge clk or posedge reset) begin
        if (reset) edges_since_rst <= 0;
        else       edges_since_rst <= edges_since_rst + 1;
    end

    // Bit order: ACT PR PRA RD WR RDA WRA REF done busy ready bg[1:0] ba[1:0]
    function automatic logic [14:0] observe();
        return {sif.ACT, sif.PR, sif.PRA, sif.RD, sif.WR, sif.RDA, sif.WRA, sif.REF,
                sif.done, sif.busy, sif.req_ready, sif.bg, sif.ba};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
        m_last_bank = 0;
    endtask

    task automatic drive_req(input bit wr, input int bgv, input int bav, input int row);
        cur_wr = wr; cur_bg = bgv; cur_ba = bav; cur_row = row;
        sif.req_wr    = wr;
        sif.req_bg    = 2'(bgv);
        sif.req_ba    = 2'(bav);
        sif.req_row   = 16'(row);
        sif.req_valid = 1'b1;
    endtask

    // Waits for the handshake, then checks every output for every cycle until done.
    task automatic run_req(input string name);
        int w, idx, pr_o, act_o, col_o, done_o, col_bit;
        logic [14:0] exp, obs;
        string kind;
        idx = cur_bg * 4 + cur_ba;
        w = 0;
        while (sif.req_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: req_ready=%b required 1 within 200 cycles", name, sif.req_ready);
            sif.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 sif.req_valid = 1'b0;
        pr_o = -1; act_o = -1;
`ifdef AUTOPRE_EN
        kind    = "closed-page";
        act_o   = 1;
        col_o   = 1 + TRCD;
        done_o  = col_o + BL + TRP;
        col_bit = cur_wr ? 8 : 9;
        m_open[idx] = 1'b0;
`else
        if (m_open[idx] && m_row[idx] == cur_row) begin
            kind  = "hit";
            col_o = 1;
        end else if (m_open[idx]) begin
            kind  = "miss";
            pr_o  = 1;
            act_o = 1 + TRP;
            col_o = act_o + TRCD;
        end else begin
            kind  = "closed";
            act_o = 1;
            col_o = 1 + TRCD;
        end
        done_o  = col_o + BL;
        col_bit = cur_wr ? 10 : 11;
        m_open[idx] = 1'b1;
        m_row[idx]  = cur_row;
`endif
        for (int off = 1; off <= done_o; off++) begin
            @(negedge clk);
            exp = '0;
            exp[14]      = (off == act_o);
            exp[13]      = (off == pr_o);
            exp[col_bit] = (off == col_o);
            exp[6]       = (off == done_o);
            exp[5]       = (off < done_o);
            exp[4]       = (off == done_o);
            exp[3:0]     = 4'(idx);
            obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s +%0d: got %b required %b (ACT PR PRA RD WR RDA WRA REF done busy ready bg ba)",
                         name, off, obs, exp);
            end
        end
        m_last_bank = idx;
        n_req++;
        $display("req %0d %s: wr=%0b bg=%0d ba=%0d row=%0d %s, done at +%0d",
                 n_req, name, cur_wr, cur_bg, cur_ba, cur_row, kind, done_o);
    endtask

    task automatic do_req(input string name, input bit wr, input int bgv, input int bav, input int row);
        drive_req(wr, bgv, bav, row);
        run_req(name);
    endtask

    task automatic wait_edges(input int target, input string name);
        int w;
        w = 0;
        while (edges_since_rst != target && w < 30000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (edges_since_rst != target) begin
            errors++;
            $display("FAIL %s wait: edge count %0d required %0d", name, edges_since_rst, target);
        end
    endtask

    // Called in the first cycle the refresh request is pending.
    task automatic check_refresh(input string name);
        bit any_open;
        int pra_o, ref_o, end_o, bank;
        logic [14:0] exp, obs;
        any_open = 1'b0;
        for (int i = 0; i < NB; i++) if (m_open[i]) any_open = 1'b1;
        pra_o = any_open ? 2 : -1;
        ref_o = any_open ? 2 + TRP : 2;
        end_o = ref_o + TRFC;
        for (int off = 0; off <= end_o; off++) begin
            if (off > 0) @(negedge clk);
            exp = '0;
            exp[12] = (off == pra_o);
            exp[7]  = (off == ref_o);
            exp[5]  = (off >= 1) && (off < end_o);
            exp[4]  = (off == end_o);
            bank = (off >= (any_open ? pra_o : ref_o)) ? 0 : m_last_bank;
            exp[3:0] = 4'(bank);
            obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s +%0d: got %b required %b (ACT PR PRA RD WR RDA WRA REF done busy ready bg ba)",
                         name, off, obs, exp);
            end
        end
        model_clear();
        $display("refresh %s: PRA=%0b REF at +%0d ready at +%0d", name, any_open, ref_o, end_o);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        reset = 1'b1;
        sif.req_valid = 1'b0; sif.req_wr = 1'b0;
        sif.req_bg = '0; sif.req_ba = '0; sif.req_row = '0;
        model_clear();
        repeat (3) @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b required %b", obs, 15'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== 15'b000000000010000) begin
            errors++;
            $display("FAIL reset_release: got %b required %b", obs, 15'b000000000010000);
        end
        $display("reset: outputs quiet in reset, ready after release");
    endtask

    task automatic test_reset_mid();
        logic [14:0] obs;
        int w;
        drive_req(1'b0, 1, 1, 5);
        w = 0;
        while (sif.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 sif.req_valid = 1'b0;
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== 15'b100000000100101) begin
            errors++;
            $display("FAIL reset_mid_act: got %b required %b", obs, 15'b100000000100101);
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 obs = observe();
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b required %b", obs, 15'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== 15'b000000000010000) begin
            errors++;
            $display("FAIL reset_mid_release: got %b required %b", obs, 15'b000000000010000);
        end
        $display("reset_mid: reset during tRCD wait returns to idle");
    endtask

    task automatic test_open_page();
        do_req("closed_read", 1'b0, 1, 1, 5);
        do_req("row_hit_read", 1'b0, 1, 1, 5);
        do_req("row_miss_write", 1'b1, 1, 1, 9);
    endtask

    task automatic test_refresh();
        wait_edges(TREFI, "refresh1");
        check_refresh("refresh1");
        do_req("after_refresh", 1'b0, 1, 1, 9);
    endtask

    task automatic test_ref_collide();
        wait_edges(2 * TREFI, "refresh2");
        drive_req(1'b0, 2, 3, 77);
        check_refresh("refresh2_collide");
        run_req("held_by_refresh");
    endtask

    task automatic test_back_to_back();
        int gap;
        logic [14:0] obs, exp;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                exp = '0;
                exp[4] = 1'b1;
                exp[3:0] = 4'(m_last_bank);
                obs = observe();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL idle_gap: got %b required %b", obs, exp);
                end
            end
            do_req("random", 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_open_page();
        test_refresh();
        test_ref_collide();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sequences the per-bank DRAM command interface (ACT/RD/WR/PR/PRA/REF strobes plus bg/ba) that feeds the bank timing FSM array.
- Accepts one read/write request at a time, tracks the open row of every bank, and inserts PR/ACT as needed.
- Enforces tRP/tRCD/tRFC/burst spacing and issues periodic all-bank refresh.
- Sits between the host request port and the TimingFSM/bank array in the memory emulator.

Parameters:
- BGWIDTH, 2, bank-group address width (0 allowed for DDR3).
- BAWIDTH, 2, bank address width.
- ROWWIDTH, 16, row address width.
- BL, 8, burst length in clock cycles.
- TRCD, 15, ACT to column command, in cycles.
- TRP, 16, PR/PRA to next ACT/REF, in cycles.
- TRFC, 34, REF to next command, in cycles.
- TREFI, 10400, refresh interval, in cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_wr  in  1  1 = write, 0 = read.
- req_bg  in  BGWIDTH  bank group.
- req_ba  in  BAWIDTH  bank.
- req_row  in  ROWWIDTH  row.
- bg  out  BGWIDTH  command bank group.
- ba  out  BAWIDTH  command bank.
- ACT, PR, PRA, RD, WR, RDA, WRA, REF  out  1 each  one-cycle command strobes.
- done  out  1  one-cycle pulse at end of a request's burst.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; open table cleared (every bank closed); refresh counter = 0; ref_pending = 0.
- Outputs are registered. At most one command strobe is high per cycle. bg/ba hold the last commanded bank; they are 0 during PRA/REF.
- req_ready = (state == IDLE) & ~ref_pending. Accepted fields are latched at the handshake.
- States and transitions:
  - IDLE:
    - ref_pending → REF_PRE.
    - Accept with row hit → COL.
    - Accept with bank open on another row → PRE.
    - Accept with bank closed → ACT.
  - PRE: pulse PR, mark bank closed → WAIT_RP. After TRP-1 further cycles → ACT.
  - ACT: pulse ACT, record row, mark bank open → WAIT_RCD. After TRCD-1 further cycles → COL.
  - COL: pulse RD or WR → BURST. After BL cycles pulse done → IDLE.
- Latencies from the accept cycle:
  - Hit: column strobe at +1.
  - Closed bank: ACT at +1, column at +1+TRCD.
  - Miss: PR at +1, ACT at +1+TRP, column at +1+TRP+TRCD.
- Refresh:
  - Counter increments every cycle. At TREFI-1 it sets ref_pending and wraps to 0; it never stops counting.
  - REF_PRE: if any bank is open, pulse PRA, clear the open table, wait TRP; otherwise skip the wait.
  - Then pulse REF, wait TRFC, clear ref_pending → IDLE.
- Simultaneous events:
  - ref_pending and req_valid in IDLE: refresh wins; the request waits with ready low.
  - Refresh expiry during a request: the request completes first.
  - Second expiry while still pending: stays a single pending refresh (no queueing).
- Reset asserted mid-operation: immediate return to reset state. No strobe may be held high.
- Wait counters are width $clog2(max(TRFC,TRP,TRCD,BL)+1) and count down to 1.

Optional Feature:
- AUTOPRE_EN, closed-page policy.
- Defined:
  - COL issues RDA/WRA instead of RD/WR, and the bank is marked closed.
  - BURST is followed by a TRP wait before done/IDLE, so every access starts from ACT.
- Undefined: open-page policy as described above. RDA/WRA are tied 0.

Decomposition:
- Package dram_sched_pkg holds:
  - the state enum;
  - the command encoding enum (NOP, ACT, PR, PRA, RD, WR, RDA, WRA, REF), decoded to strobes at the output register;
  - default timing localparams.
- One sub-module, refresh_timer: TREFI counter plus sticky pending flag with clear input.

Test Plan:
- Reset mid-ACT-wait, then release → all strobes 0, req_ready = 1 next cycle, open table empty (the next request to the same bank issues ACT).
- Read bg=1 ba=1 row=5 to a closed bank → ACT at +1, RD at +16, done at +24.
- Second read bg=1 ba=1 row=5 → RD at +1 with no ACT; then write row=9 → PR at +1, ACT at +17, WR at +32.
- Advance to refresh with bank 1/1 open → PRA, REF 16 cycles later, req_ready low for 16+34 cycles; a following access to row 9 issues ACT.
- req_valid asserted in the same cycle ref_pending sets → REF sequence first, then the request is accepted.
- AUTOPRE_EN: two reads to the same row → each issues ACT then RDA, and no PR is ever issued.
